// File: rtl/dce_pkg.sv
// Shared definitions for the 8-switch debouncer: FSM encoding, default
// debounce length and pattern-classification helpers.
package dce_pkg;

  localparam int unsigned DEB_CYCLES_DEFAULT = 1000000;

  typedef enum logic {
    IDLE     = 1'b0,
    SETTLING = 1'b1
  } deb_state_t;

  // Exactly one bit set (zero is not one-hot).
  function automatic logic is_one_hot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

  // Two or more bits set: clearing the lowest set bit leaves something behind.
  function automatic logic is_multi(input logic [7:0] v);
    return (v & (v - 8'd1)) != 8'h00;
  endfunction

endpackage

// File: rtl/switch_debounce_8.sv
// Debounces eight slide switches as one pattern and flags whether the accepted
// pattern is one-hot (encoder enable) or has several bits set.
module switch_debounce_8
  import dce_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  output logic [7:0] x_out,
  output logic       en_out,
  output logic       multi,
  output logic       chg
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    cand;
  logic [CW-1:0] cnt;
  deb_state_t    state_q;
  deb_state_t    state_d;

  logic differs;
  logic expired;
  logic commit;

  // A new sample always wins over expiry, so a change on the last count
  // cycle restarts the window instead of committing the old candidate.
  assign differs = (sync2 != cand);
  assign expired = (state_q == SETTLING) && !differs && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (differs)      state_d = SETTLING;
    else if (expired) state_d = IDLE;
  end

  // Output decision: only a candidate that differs from the accepted pattern
  // is committed, so a glitch returning to x_out produces no pulse.
  always_comb begin
    commit = expired && (cand != x_out);
  end

  // Synchronizer, candidate/counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: every flop here is reset; the block is small and an abandoned
      // count must not leak a pattern out after reset.
      sync1  <= 8'h00;
      sync2  <= 8'h00;
      cand   <= 8'h00;
      cnt    <= '0;
      x_out  <= 8'h00;
      en_out <= 1'b0;
      multi  <= 1'b0;
      chg    <= 1'b0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
      chg   <= commit;

      if (differs) begin
        cand <= sync2;
        cnt  <= '0;
      end else if ((state_q == SETTLING) && (cnt != CNT_LAST)) begin
        cnt <= cnt + CW'(1);
      end

      // Flags derive from the incoming value so they align with x_out and chg.
      if (commit) begin
        x_out  <= cand;
        en_out <= is_one_hot(cand);
        multi  <= is_multi(cand);
      end
    end
  end

endmodule

// File: tb/tb_switch_debounce_8.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized switch activity compared every cycle against a run-length model.
module tb_switch_debounce_8;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw  = 8'h00;
  logic [7:0] x_out;
  logic       en_out;
  logic       multi;
  logic       chg;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  switch_debounce_8 #(.DEB_CYCLES(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .sw    (sw),
    .x_out (x_out),
    .en_out(en_out),
    .multi (multi),
    .chg   (chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a pattern is accepted once the synchronized input has shown it on
  // D+1 consecutive edges and it differs from the currently accepted pattern.
  logic [7:0] m_s1, m_s2, m_x, run_val;
  int         run_len;
  bit         m_chg;

  always @(posedge clk) begin
    logic [7:0] seen;
    if (rst) begin
      m_s1 = 8'h00; m_s2 = 8'h00; m_x = 8'h00;
      run_val = 8'h00; run_len = D + 2; m_chg = 1'b0;
    end else begin
      seen = m_s2;
      m_s2 = m_s1;
      m_s1 = sw;
      m_chg = 1'b0;
      if (seen == run_val) begin
        if (run_len < D + 2) run_len++;
      end else begin
        run_val = seen;
        run_len = 1;
      end
      if (run_len == D + 1 && run_val != m_x) begin
        m_x   = run_val;
        m_chg = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_x_out", x_out, m_x);
      check("model_en_out", en_out, ($countones(m_x) == 1));
      check("model_multi", multi, ($countones(m_x) >= 2));
      check("model_chg", chg, m_chg);
    end
  end

  function automatic logic [2:0] encode(input logic [7:0] v, input logic en);
    logic [2:0] y = 3'b000;
    if (en)
      for (int i = 0; i < 8; i++)
        if (v[i]) y = 3'(i);
    return y;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic no_chg_for(input string name, input int n);
    int pulses = 0;
    repeat (n) begin
      step(1);
      if (chg) pulses++;
    end
    check(name, pulses, 0);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1; sw = 8'h00;
    step(2);
    started = 1'b1;
    check("rst_x_out", x_out, 8'h00);
    check("rst_en_out", en_out, 1'b0);
    check("rst_multi", multi, 1'b0);
    check("rst_chg", chg, 1'b0);

    // One-hot pattern held: accepted exactly D+3 edges later.
    rst = 1'b0; sw = 8'h04;
    step(6);
    check("onehot_early_x", x_out, 8'h00);
    step(1);
    check("onehot_x", x_out, 8'h04);
    check("onehot_en", en_out, 1'b1);
    check("onehot_multi", multi, 1'b0);
    check("onehot_chg", chg, 1'b1);
    step(1);
    check("onehot_chg_drop", chg, 1'b0);

    // Short glitch to 8'h08 returning to the accepted pattern.
    sw = 8'h08;
    step(2);
    sw = 8'h04;
    no_chg_for("glitch_no_chg", 12);
    check("glitch_x", x_out, 8'h04);

    // Two bits set: accepted, enable low, multi high, single pulse.
    sw = 8'h11;
    step(7);
    check("multi_x", x_out, 8'h11);
    check("multi_en", en_out, 1'b0);
    check("multi_multi", multi, 1'b1);
    check("multi_chg", chg, 1'b1);
    no_chg_for("multi_single_pulse", 10);

    // 8'h01 starts settling, switches to 8'h02 right at the old expiry edge.
    sw = 8'h01;
    step(4);
    sw = 8'h02;
    step(6);
    check("restart_hold_x", x_out, 8'h11);
    step(1);
    check("restart_x", x_out, 8'h02);
    check("restart_chg", chg, 1'b1);
    step(4);

    // Reset during settling toward 8'h80, then acceptance after release.
    sw = 8'h80;
    step(4);
    rst = 1'b1;
    step(1);
    check("midrst_x", x_out, 8'h00);
    check("midrst_chg", chg, 1'b0);
    check("midrst_en", en_out, 1'b0);
    rst = 1'b0;
    step(6);
    check("postrst_early_x", x_out, 8'h00);
    step(1);
    check("postrst_x", x_out, 8'h80);
    check("postrst_chg", chg, 1'b1);

    // Chained with an 8-to-3 encoder.
    sw = 8'h40;
    step(8);
    check("enc_en_40", en_out, 1'b1);
    check("enc_y_40", encode(x_out, en_out), 3'b110);
    sw = 8'h00;
    step(8);
    check("enc_en_00", en_out, 1'b0);
    check("enc_y_00", encode(x_out, en_out), 3'b000);

    // Randomized bouncing, holds around the debounce window, occasional resets.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: sw = 8'(1 << $urandom_range(0, 7));
        1: sw = 8'($urandom);
        2: sw = sw;
        default: sw = 8'h00;
      endcase
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      step($urandom_range(1, 9));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
